user_obi_addr_demux: RTL and testbench



---
 rtl/croc_pkg.sv | 11 +
 rtl/user_pkg.sv | 35 +++
 rtl/user_obi_err_sbr.sv | 40 ++++
 rtl/user_obi_addr_demux.sv | 152 +++++++++++++++
 tb/tb_user_obi_addr_demux.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/croc_pkg.sv
// Shared SoC-level types used by the address decoders.
package croc_pkg;

    // Half-open address rule [start_addr, end_addr) that routes to output idx.
    typedef struct packed {
        logic [31:0] idx;
        logic [31:0] start_addr;
        logic [31:0] end_addr;
    } addr_map_rule_t;

endpackage

// File: rtl/user_pkg.sv
// User-domain address map and demux configuration.
package user_pkg;

    localparam logic [31:0] UserRomAddrOffset       = 32'h2000_0000;
    localparam logic [31:0] UserRomAddrRange        = 32'h0000_1000;
    localparam logic [31:0] UserBlockSwapAddrOffset = 32'h2000_1000;
    localparam logic [31:0] UserBlockSwapAddrRange  = 32'h0000_1000;
    localparam logic [31:0] UserSpiAddrOffset       = 32'h2000_2000;
    localparam logic [31:0] UserSpiAddrRange        = 32'h0000_1000;

    // Output 0 is the built-in error subordinate.
    typedef enum int unsigned {
        UserError     = 0,
        UserRom       = 1,
        UserBlockSwap = 2,
        UserSpi       = 3,
        NumDemuxSbr
    } user_demux_outputs_e;

    localparam int unsigned NumDemuxSbrRules = NumDemuxSbr - 1;
    localparam int unsigned UserMaxTrans     = 4;

    localparam croc_pkg::addr_map_rule_t [NumDemuxSbrRules-1:0] user_addr_map = '{
        '{idx: 32'(UserSpi),
          start_addr: UserSpiAddrOffset,
          end_addr:   UserSpiAddrOffset + UserSpiAddrRange},
        '{idx: 32'(UserBlockSwap),
          start_addr: UserBlockSwapAddrOffset,
          end_addr:   UserBlockSwapAddrOffset + UserBlockSwapAddrRange},
        '{idx: 32'(UserRom),
          start_addr: UserRomAddrOffset,
          end_addr:   UserRomAddrOffset + UserRomAddrRange}
    };

endpackage

// File: rtl/user_obi_err_sbr.sv
// One-cycle OBI error responder: every accepted request is answered the next
// cycle with err=1 and a fixed data word. Accepts one request per cycle.
module user_obi_err_sbr #(
    parameter int unsigned IdWidth = 1,
    parameter logic [31:0] ErrData = 32'hBADC_AB1E
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               req_i,
    input  logic [IdWidth-1:0] aid_i,
    output logic               gnt_o,
    output logic               rvalid_o,
    output logic               err_o,
    output logic [31:0]        rdata_o,
    output logic [IdWidth-1:0] rid_o
);

    logic               valid_q;
    logic [IdWidth-1:0] aid_q;

    // The response register frees up in the same cycle it is presented,
    // so a new request can always be taken.
    assign gnt_o    = 1'b1;
    assign rvalid_o = valid_q;
    assign err_o    = 1'b1;
    assign rdata_o  = ErrData;
    assign rid_o    = aid_q;

    // Capture the accepted request's id and schedule its response.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            aid_q   <= '0;
        end else begin
            valid_q <= req_i & gnt_o;
            if (req_i & gnt_o) aid_q <= aid_i;
        end
    end

endmodule

// File: rtl/user_obi_addr_demux.sv
// OBI address demultiplexer for the user domain with per-target ordering and
// a built-in error subordinate on output 0.
module user_obi_addr_demux
    import croc_pkg::*;
    import user_pkg::*;
#(
    parameter int unsigned    NumRules = 3,
    parameter int unsigned    NumSbr   = NumRules + 1,
    parameter int unsigned    MaxTrans = UserMaxTrans,
    parameter int unsigned    IdWidth  = 1,
    parameter addr_map_rule_t [NumRules-1:0] AddrMap = user_addr_map
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [NumRules-1:0]             rule_en_i,
    input  logic                            req_i,
    input  logic                            we_i,
    input  logic [31:0]                     addr_i,
    input  logic [3:0]                      be_i,
    input  logic [31:0]                     wdata_i,
    input  logic [IdWidth-1:0]              aid_i,
    output logic                            gnt_o,
    output logic                            rvalid_o,
    output logic [31:0]                     rdata_o,
    output logic                            err_o,
    output logic [IdWidth-1:0]              rid_o,
    output logic [NumSbr-1:0]               sbr_req_o,
    output logic                            sbr_we_o,
    output logic [31:0]                     sbr_addr_o,
    output logic [3:0]                      sbr_be_o,
    output logic [31:0]                     sbr_wdata_o,
    output logic [IdWidth-1:0]              sbr_aid_o,
    input  logic [NumSbr-1:0]               sbr_gnt_i,
    input  logic [NumSbr-1:0]               sbr_rvalid_i,
    input  logic [NumSbr-1:0]               sbr_err_i,
    input  logic [NumSbr-1:0][31:0]         sbr_rdata_i,
    input  logic [NumSbr-1:0][IdWidth-1:0]  sbr_rid_i
);

    localparam int unsigned SelW = (NumSbr > 1) ? $clog2(NumSbr) : 1;
    localparam int unsigned CntW = $clog2(MaxTrans + 1);

    logic [SelW-1:0]                 sel, cur_q;
    logic [CntW-1:0]                 cnt_q;
    logic                            matched;
    logic                            rsp_fire, hs, stall;
    logic                            err_req, err_gnt, err_rvalid, err_err;
    logic [31:0]                     err_rdata;
    logic [IdWidth-1:0]              err_rid;
    logic [NumSbr-1:0]               gnt, rvalid, err, stray_rvalid;
    logic [NumSbr-1:0][31:0]         rdata;
    logic [NumSbr-1:0][IdWidth-1:0]  rid;

    assign sbr_we_o    = we_i;
    assign sbr_addr_o  = addr_i;
    assign sbr_be_o    = be_i;
    assign sbr_wdata_o = wdata_i;
    assign sbr_aid_o   = aid_i;

    // Lowest-numbered enabled rule containing addr_i wins; no match -> 0.
    always_comb begin
        sel     = '0;
        matched = 1'b0;
        for (int unsigned r = 0; r < NumRules; r++) begin
            if (!matched && rule_en_i[r] &&
                addr_i >= AddrMap[r].start_addr && addr_i < AddrMap[r].end_addr) begin
                sel     = AddrMap[r].idx[SelW-1:0];
                matched = 1'b1;
            end
        end
    end

    // Merge the internal error subordinate into slot 0 of the response vectors.
    always_comb begin
        gnt       = sbr_gnt_i;
        rvalid    = sbr_rvalid_i;
        err       = sbr_err_i;
        rdata     = sbr_rdata_i;
        rid       = sbr_rid_i;
        gnt[0]    = err_gnt;
        rvalid[0] = err_rvalid;
        err[0]    = err_err;
        rdata[0]  = err_rdata;
        rid[0]    = err_rid;
    end

    assign rsp_fire = rvalid[cur_q];
    assign rvalid_o = rsp_fire;
    assign rdata_o  = rdata[cur_q];
    assign err_o    = err[cur_q];
    assign rid_o    = rid[cur_q];

    // Stall checks use the count after this cycle's retiring response, so a
    // response frees its slot (or ends a target's run) for a same-cycle grant.
    always_comb begin
        stall = 1'b0;
        if (cnt_q == CntW'(MaxTrans) && !rsp_fire) stall = 1'b1;
        if (cnt_q != '0 && sel != cur_q && !(cnt_q == CntW'(1) && rsp_fire)) stall = 1'b1;
    end

    // Route the request to the selected output unless stalled.
    always_comb begin
        sbr_req_o = '0;
        err_req   = 1'b0;
        gnt_o     = 1'b0;
        if (!stall) begin
            gnt_o = req_i & gnt[sel];
            if (sel == '0) err_req = req_i;
            else           sbr_req_o[sel] = req_i;
        end
    end

    assign hs = req_i & gnt_o;

    // Track the current target and its outstanding transaction count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cur_q <= '0;
            cnt_q <= '0;
        end else begin
            if (hs) cur_q <= sel;
            if (hs && !rsp_fire && cnt_q != CntW'(MaxTrans)) cnt_q <= cnt_q + CntW'(1);
            else if (!hs && rsp_fire && cnt_q != '0)        cnt_q <= cnt_q - CntW'(1);
        end
    end

    user_obi_err_sbr #(
        .IdWidth (IdWidth),
        .ErrData (32'hBADC_AB1E)
    ) i_err_sbr (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .req_i    (err_req),
        .aid_i    (aid_i),
        .gnt_o    (err_gnt),
        .rvalid_o (err_rvalid),
        .err_o    (err_err),
        .rdata_o  (err_rdata),
        .rid_o    (err_rid)
    );

    // Responses from any output other than the current target are illegal.
    always_comb begin
        stray_rvalid = '0;
        for (int unsigned i = 1; i < NumSbr; i++) begin
            if (SelW'(i) != cur_q) stray_rvalid[i] = sbr_rvalid_i[i];
        end
    end

    assert property (@(posedge clk_i) disable iff (!rst_ni) (stray_rvalid == '0));

endmodule

// File: tb/tb_user_obi_addr_demux.sv
module tb_user_obi_addr_demux;
    localparam int unsigned NR = 3;
    localparam int unsigned NS = 4;
    localparam int unsigned MT = 4;
    localparam int unsigned IW = 1;

    localparam croc_pkg::addr_map_rule_t [NR-1:0] TbMap = '{
        '{idx: 32'd3, start_addr: 32'h5000_0000, end_addr: 32'h5000_1000},
        '{idx: 32'd2, start_addr: 32'h4000_0000, end_addr: 32'h8000_0000},
        '{idx: 32'd1, start_addr: 32'h2000_0000, end_addr: 32'h2000_1000}
    };

    // Reference copy of the rule table as plain numbers.
    bit [31:0] ref_lo  [NR] = '{32'h2000_0000, 32'h4000_0000, 32'h5000_0000};
    bit [31:0] ref_hi  [NR] = '{32'h2000_1000, 32'h8000_0000, 32'h5000_1000};
    int        ref_idx [NR] = '{1, 2, 3};

    logic                     clk_i = 1'b0;
    logic                     rst_ni;
    logic [NR-1:0]            rule_en_i;
    logic                     req_i, we_i;
    logic [31:0]              addr_i, wdata_i;
    logic [3:0]               be_i;
    logic [IW-1:0]            aid_i;
    logic                     gnt_o, rvalid_o, err_o;
    logic [31:0]              rdata_o;
    logic [IW-1:0]            rid_o;
    logic [NS-1:0]            sbr_req_o;
    logic                     sbr_we_o;
    logic [31:0]              sbr_addr_o, sbr_wdata_o;
    logic [3:0]               sbr_be_o;
    logic [IW-1:0]            sbr_aid_o;
    logic [NS-1:0]            sbr_gnt_i, sbr_rvalid_i, sbr_err_i;
    logic [NS-1:0][31:0]      sbr_rdata_i;
    logic [NS-1:0][IW-1:0]    sbr_rid_i;

    user_obi_addr_demux #(
        .NumRules (NR),
        .NumSbr   (NS),
        .MaxTrans (MT),
        .IdWidth  (IW),
        .AddrMap  (TbMap)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .rule_en_i    (rule_en_i),
        .req_i        (req_i),
        .we_i         (we_i),
        .addr_i       (addr_i),
        .be_i         (be_i),
        .wdata_i      (wdata_i),
        .aid_i        (aid_i),
        .gnt_o        (gnt_o),
        .rvalid_o     (rvalid_o),
        .rdata_o      (rdata_o),
        .err_o        (err_o),
        .rid_o        (rid_o),
        .sbr_req_o    (sbr_req_o),
        .sbr_we_o     (sbr_we_o),
        .sbr_addr_o   (sbr_addr_o),
        .sbr_be_o     (sbr_be_o),
        .sbr_wdata_o  (sbr_wdata_o),
        .sbr_aid_o    (sbr_aid_o),
        .sbr_gnt_i    (sbr_gnt_i),
        .sbr_rvalid_i (sbr_rvalid_i),
        .sbr_err_i    (sbr_err_i),
        .sbr_rdata_i  (sbr_rdata_i),
        .sbr_rid_i    (sbr_rid_i)
    );

    always #5 clk_i = ~clk_i;

    int tests = 0;
    int fails = 0;

    // Reference model state: who owns the outstanding transactions and how many.
    int        m_cnt;
    int        m_tgt;
    bit        m_err_due;
    bit [IW-1:0] m_err_aid;

    // Response payload the bench returns when it answers a transaction.
    logic [31:0]   rv_data;
    logic          rv_err;
    logic [IW-1:0] rv_rid;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int ref_decode(input logic [31:0] a, input logic [NR-1:0] en);
        for (int r = 0; r < NR; r++)
            if (en[r] && a >= ref_lo[r] && a < ref_hi[r]) return ref_idx[r];
        return 0;
    endfunction

    task automatic model_reset();
        m_cnt = 0;
        m_tgt = 0;
        m_err_due = 1'b0;
        m_err_aid = '0;
    endtask

    // One clock cycle: optionally answer the current target, check all
    // combinational outputs against the model, then advance the model.
    task automatic step(input bit want_rv);
        int s, after;
        bit rsp, can, sub_gnt, exp_gnt;
        logic [NS-1:0] exp_req;
        sbr_rvalid_i = '0;
        if (want_rv && m_cnt > 0 && m_tgt != 0) begin
            sbr_rvalid_i[m_tgt] = 1'b1;
            sbr_rdata_i[m_tgt]  = rv_data;
            sbr_err_i[m_tgt]    = rv_err;
            sbr_rid_i[m_tgt]    = rv_rid;
        end
        #2;
        s       = ref_decode(addr_i, rule_en_i);
        rsp     = (m_cnt > 0) && ((m_tgt == 0) ? m_err_due : sbr_rvalid_i[m_tgt]);
        after   = m_cnt - int'(rsp);
        can     = (after == 0) || (s == m_tgt && after < MT);
        sub_gnt = (s == 0) ? 1'b1 : sbr_gnt_i[s];
        exp_gnt = req_i && can && sub_gnt;
        exp_req = '0;
        if (req_i && can && s != 0) exp_req[s] = 1'b1;
        check("gnt", 32'(gnt_o), 32'(exp_gnt));
        check("sbr_req", 32'(sbr_req_o), 32'(exp_req));
        check("rvalid", 32'(rvalid_o), 32'(rsp));
        check("sbr_addr", sbr_addr_o, addr_i);
        if (rsp) begin
            if (m_tgt == 0) begin
                check("err_rdata", rdata_o, 32'hBADC_AB1E);
                check("err_err", 32'(err_o), 32'd1);
                check("err_rid", 32'(rid_o), 32'(m_err_aid));
            end else begin
                check("rdata", rdata_o, rv_data);
                check("err", 32'(err_o), 32'(rv_err));
                check("rid", 32'(rid_o), 32'(rv_rid));
            end
        end
        @(posedge clk_i);
        m_err_due = exp_gnt && s == 0;
        if (m_err_due) m_err_aid = aid_i;
        if (exp_gnt) m_tgt = s;
        m_cnt = m_cnt + int'(exp_gnt) - int'(rsp);
        #1;
    endtask

    task automatic set_req(input bit r, input logic [31:0] a, input logic [IW-1:0] id);
        req_i  = r;
        addr_i = a;
        aid_i  = id;
    endtask

    initial begin
        rst_ni       = 1'b0;
        rule_en_i    = '1;
        req_i        = 1'b0;
        we_i         = 1'b0;
        addr_i       = '0;
        be_i         = 4'hF;
        wdata_i      = '0;
        aid_i        = '0;
        sbr_gnt_i    = '0;
        sbr_rvalid_i = '0;
        sbr_err_i    = '0;
        sbr_rdata_i  = '0;
        sbr_rid_i    = '0;
        rv_data      = '0;
        rv_err       = 1'b0;
        rv_rid       = '0;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_gnt", 32'(gnt_o), 32'd0);
        check("rst_rvalid", 32'(rvalid_o), 32'd0);
        check("rst_sbr_req", 32'(sbr_req_o), 32'd0);
        rst_ni = 1'b1;

        // Plain read to rule 0 (idx 1) and its response
        sbr_gnt_i = 4'b0010;
        set_req(1'b1, 32'h2000_0004, 1'b0);
        step(1'b0);
        set_req(1'b0, 32'h2000_0004, 1'b0);
        rv_data = 32'h1234_5678; rv_err = 1'b0; rv_rid = 1'b0;
        step(1'b1);

        // Unmapped access answered by the error subordinate
        set_req(1'b1, 32'h3000_0000, 1'b1);
        step(1'b0);
        set_req(1'b0, 32'h3000_0000, 1'b0);
        step(1'b0);

        // Disabled rule falls through to the error subordinate
        rule_en_i = 3'b110;
        set_req(1'b1, 32'h2000_0004, 1'b1);
        step(1'b0);
        set_req(1'b0, 32'h2000_0004, 1'b0);
        step(1'b0);
        rule_en_i = '1;

        // Two outstanding to idx 1, then a switch to idx 3 waits for both
        sbr_gnt_i = 4'b1010;
        set_req(1'b1, 32'h2000_0010, 1'b0);
        step(1'b0);
        step(1'b0);
        rule_en_i = 3'b101;
        set_req(1'b1, 32'h5000_0010, 1'b0);
        step(1'b0);
        rv_data = 32'hAAAA_0001;
        step(1'b1);
        rv_data = 32'hAAAA_0002;
        step(1'b1);
        set_req(1'b0, 32'h5000_0010, 1'b0);
        rv_data = 32'hAAAA_0003; rv_rid = 1'b1;
        step(1'b1);
        rule_en_i = '1;
        rv_rid = 1'b0;

        // Fill to MaxTrans, 5th stalls, then grant alongside a response
        set_req(1'b1, 32'h2000_0020, 1'b0);
        repeat (5) step(1'b0);
        rv_data = 32'hBBBB_0000;
        step(1'b1);
        set_req(1'b0, 32'h2000_0020, 1'b0);
        repeat (4) begin
            rv_data = rv_data + 32'd1;
            step(1'b1);
        end
        check("drain_cnt", 32'(m_cnt), 32'd0);

        // Overlap: rule 1 wins over nested rule 2
        sbr_gnt_i = 4'b1110;
        set_req(1'b1, 32'h5000_0010, 1'b0);
        step(1'b0);
        set_req(1'b0, 32'h5000_0010, 1'b0);
        rv_data = 32'hCCCC_0001; rv_err = 1'b1;
        step(1'b1);
        rv_err = 1'b0;

        // Asynchronous reset with three outstanding
        set_req(1'b1, 32'h2000_0030, 1'b0);
        repeat (3) step(1'b0);
        set_req(1'b0, 32'h2000_0030, 1'b0);
        rst_ni = 1'b0;
        sbr_rvalid_i[1] = 1'b1;
        #1;
        check("async_rst_rvalid", 32'(rvalid_o), 32'd0);
        check("async_rst_sbr_req", 32'(sbr_req_o), 32'd0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        sbr_rvalid_i = '0;
        model_reset();
        set_req(1'b1, 32'h5000_0040, 1'b0);
        step(1'b0);
        set_req(1'b0, 32'h5000_0040, 1'b0);
        rv_data = 32'hDDDD_0001;
        step(1'b1);

        // Randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            if (c % 16 == 0) rule_en_i = NR'($urandom);
            req_i = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 7))
                0: addr_i = 32'h2000_0000 + 32'($urandom_range(0, 32'hFFF));
                1: addr_i = 32'h3000_0000;
                2: addr_i = 32'h4000_0100;
                3: addr_i = 32'h5000_0010;
                4: addr_i = 32'h2000_0FFC;
                5: addr_i = 32'h2000_1000;
                6: addr_i = 32'h1FFF_FFFC;
                default: addr_i = 32'h8000_0000;
            endcase
            aid_i       = IW'($urandom);
            we_i        = 1'($urandom);
            wdata_i     = $urandom;
            sbr_gnt_i   = NS'($urandom);
            for (int k = 0; k < NS; k++) sbr_rdata_i[k] = $urandom;
            sbr_err_i   = NS'($urandom);
            rv_data     = $urandom;
            rv_err      = 1'($urandom);
            rv_rid      = IW'($urandom);
            step($urandom_range(0, 2) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
